// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with one output register stage,
// fixed or round-robin selection. Optional packet lock: STREAM_MUX_PKT_LOCK_EN.
module stream_mux_rr #(
    parameter int NCH   = 4,
    parameter int WIDTH = 8,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
    input  logic [NCH-1:0]       in_last,
    output logic                 out_last,
`endif
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_ch
);

    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] rr_grant;
    logic            rr_vld;
    logic [SELW-1:0] base_grant;
    logic            base_vld;
    logic [SELW-1:0] grant;
    logic            grant_vld;
    logic            load_en;
    logic            xfer;
    logic            ptr_adv;

    // Round-robin search: first valid channel starting at ptr, wrapping at NCH-1.
    always_comb begin : rr_search
        int idx;
        // NOTE: every variable written in always_comb gets a default first, so no latch can be inferred.
        idx      = 0;
        rr_grant = '0;
        rr_vld   = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!rr_vld && in_valid[idx]) begin
                rr_vld   = 1'b1;
                rr_grant = SELW'(idx);
            end
        end
    end

    always_comb begin : base_select
        base_grant = '0;
        base_vld   = 1'b0;
        if (mode) begin
            base_grant = rr_grant;
            base_vld   = rr_vld;
        end else if (int'(sel) < NCH) begin
            base_grant = sel;
            base_vld   = in_valid[sel];
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    typedef enum logic {
        IDLE,
        LOCKED
    } lock_state_t;

    lock_state_t     state;
    lock_state_t     state_nxt;
    logic [SELW-1:0] lock_ch;
    logic [SELW-1:0] lock_ch_nxt;

    // A locked packet owns the output regardless of mode, sel or other requesters.
    always_comb begin : grant_select
        grant     = base_grant;
        grant_vld = base_vld;
        if (state == LOCKED) begin
            grant     = lock_ch;
            grant_vld = in_valid[lock_ch];
        end
    end

    always_ff @(posedge clk) begin : lock_reg
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state   <= IDLE;
            lock_ch <= '0;
        end else begin
            state   <= state_nxt;
            lock_ch <= lock_ch_nxt;
        end
    end

    always_comb begin : lock_next
        state_nxt   = state;
        lock_ch_nxt = lock_ch;
        case (state)
            IDLE: begin
                if (xfer && !in_last[grant]) begin
                    state_nxt   = LOCKED;
                    lock_ch_nxt = grant;
                end
            end
            LOCKED: begin
                if (xfer && in_last[grant]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ptr_adv = xfer && mode && in_last[grant];
`else
    assign grant     = base_grant;
    assign grant_vld = base_vld;
    assign ptr_adv   = xfer && mode;
`endif

    assign load_en = !out_valid || out_ready;
    // Reset gates the handshake so no producer sees a transfer while the block is held in reset.
    assign xfer    = load_en && grant_vld && !rst;

    always_comb begin : ready_decode
        in_ready = '0;
        if (xfer) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin : out_reg
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
            out_last  <= 1'b0;
`endif
        end else if (load_en) begin
            out_valid <= grant_vld;
            if (grant_vld) begin
                out_data <= in_data[int'(grant)*WIDTH +: WIDTH];
                out_ch   <= grant;
`ifdef STREAM_MUX_PKT_LOCK_EN
                out_last <= in_last[grant];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin : ptr_reg
        if (rst) begin
            ptr <= '0;
        end else if (ptr_adv) begin
            ptr <= (grant == LAST_CH) ? '0 : grant + 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel and a 3-channel instance share clock and reset.
// Packet-lock vectors run only when STREAM_MUX_PKT_LOCK_EN is defined.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 4-channel instance
    logic [31:0] a_in_data;
    logic [3:0]  a_in_valid;
    logic [3:0]  a_in_ready;
    logic        a_mode;
    logic [1:0]  a_sel;
    logic [7:0]  a_out_data;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [1:0]  a_out_ch;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic [3:0]  a_in_last;
    logic        a_out_last;
`endif

    // 3-channel instance
    logic [23:0] b_in_data;
    logic [2:0]  b_in_valid;
    logic [2:0]  b_in_ready;
    logic        b_mode;
    logic [1:0]  b_sel;
    logic [7:0]  b_out_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [1:0]  b_out_ch;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic [2:0]  b_in_last;
    logic        b_out_last;
`endif

    stream_mux_rr #(.NCH(4), .WIDTH(8)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .in_last   (a_in_last),
        .out_last  (a_out_last),
`endif
        .mode      (a_mode),
        .sel       (a_sel),
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_ch    (a_out_ch)
    );

    stream_mux_rr #(.NCH(3), .WIDTH(8)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .in_last   (b_in_last),
        .out_last  (b_out_last),
`endif
        .mode      (b_mode),
        .sel       (b_sel),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_ch    (b_out_ch)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] rr_seq [5];
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst         = 1'b1;
        a_in_data   = '0;
        a_in_valid  = 4'hF;
        a_mode      = 1'b0;
        a_sel       = 2'd0;
        a_out_ready = 1'b1;
        b_in_data   = '0;
        b_in_valid  = 3'b111;
        b_mode      = 1'b0;
        b_sel       = 2'd0;
        b_out_ready = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
        a_in_last   = 4'hF;
        b_in_last   = 3'h7;
`endif
        tick();
        tick();

        // Reset state, with requests present to show in_ready is held low.
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_data",  32'(a_out_data),  32'h00);
        check("rst_out_ch",    32'(a_out_ch),    32'd0);
        check("rst_in_ready",  32'(a_in_ready),  32'h0);
        check("rst_b_in_ready", 32'(b_in_ready), 32'h0);
`ifdef STREAM_MUX_PKT_LOCK_EN
        check("rst_out_last",  32'(a_out_last),  32'd0);
`endif

        rst        = 1'b0;
        a_in_valid = 4'h0;
        b_in_valid = 3'b000;

        // Fixed select, sel=2, only ch2 valid.
        a_in_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
        a_sel      = 2'd2;
        a_in_valid = 4'b0100;
        #1;
        check("fix_in_ready", 32'(a_in_ready), 32'b0100);
        tick();
        check("fix_out_valid", 32'(a_out_valid), 32'd1);
        check("fix_out_data",  32'(a_out_data),  32'hA5);
        check("fix_out_ch",    32'(a_out_ch),    32'd2);

        // Selected channel idle while another is valid: no grant.
        a_sel      = 2'd1;
        a_in_valid = 4'b0100;
        #1;
        check("fix_idle_ready", 32'(a_in_ready), 32'h0);
        tick();
        check("fix_idle_drop", 32'(a_out_valid), 32'd0);

        // Round robin with all channels valid: 0,1,2,3,0 back to back.
        a_in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        a_mode     = 1'b1;
        a_in_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("rr_ready_%0d", i), 32'(a_in_ready), 32'(4'b0001 << rr_seq[i]));
            tick();
            check($sformatf("rr_valid_%0d", i), 32'(a_out_valid), 32'd1);
            check($sformatf("rr_ch_%0d", i),    32'(a_out_ch),    32'(rr_seq[i]));
            check($sformatf("rr_data_%0d", i),  32'(a_out_data),  32'h10 + 32'(rr_seq[i]));
        end

        // Backpressure: word ch0/0x10 held for 5 cycles while ch0 data changes.
        a_out_ready = 1'b0;
        a_in_data   = {8'h13, 8'h12, 8'h11, 8'h99};
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_ready_%0d", i), 32'(a_in_ready), 32'h0);
            tick();
            check($sformatf("bp_data_%0d", i), 32'(a_out_data), 32'h10);
            check($sformatf("bp_ch_%0d", i),   32'(a_out_ch),   32'd0);
        end

        // Release: pop and reload in one cycle, pointer resumes at ch1.
        a_out_ready = 1'b1;
        #1;
        check("rel_ready", 32'(a_in_ready), 32'b0010);
        tick();
        check("rel_valid", 32'(a_out_valid), 32'd1);
        check("rel_ch",    32'(a_out_ch),    32'd1);
        check("rel_data",  32'(a_out_data),  32'h11);

        a_in_valid = 4'h0;
        tick();
        check("pop_drop", 32'(a_out_valid), 32'd0);

        // Reset while a word is held: word discarded, pointer back to 0.
        a_in_valid  = 4'b1000;
        tick();
        check("mid_load", 32'(a_out_ch), 32'd3);
        a_out_ready = 1'b0;
        rst         = 1'b1;
        tick();
        check("mid_rst_valid", 32'(a_out_valid), 32'd0);
        check("mid_rst_data",  32'(a_out_data),  32'h00);
        check("mid_rst_ch",    32'(a_out_ch),    32'd0);
        rst         = 1'b0;
        a_out_ready = 1'b1;
        a_in_valid  = 4'hF;
        #1;
        check("mid_rst_ptr", 32'(a_in_ready), 32'b0001);
        a_in_valid  = 4'h0;
        tick();
        tick();

        // NCH=3 wrap: ch2 alone, then ch0+ch2 (ptr wrapped to 0), then ch0+ch2 (ptr=1).
        b_in_data  = {8'hC2, 8'hC1, 8'hC0};
        b_mode     = 1'b1;
        b_in_valid = 3'b100;
        #1;
        check("wrap_ready_0", 32'(b_in_ready), 32'b100);
        tick();
        check("wrap_ch_0",   32'(b_out_ch),   32'd2);
        check("wrap_data_0", 32'(b_out_data), 32'hC2);
        b_in_valid = 3'b101;
        #1;
        check("wrap_ready_1", 32'(b_in_ready), 32'b001);
        tick();
        check("wrap_ch_1", 32'(b_out_ch), 32'd0);
        #1;
        check("wrap_ready_2", 32'(b_in_ready), 32'b100);
        tick();
        check("wrap_ch_2", 32'(b_out_ch), 32'd2);
        b_in_valid = 3'b000;
        tick();
        check("wrap_drop", 32'(b_out_valid), 32'd0);

        // NCH=3 out-of-range select.
        b_mode     = 1'b0;
        b_sel      = 2'd3;
        b_in_valid = 3'b111;
        #1;
        check("bad_sel_ready", 32'(b_in_ready), 32'h0);
        tick();
        check("bad_sel_valid_0", 32'(b_out_valid), 32'd0);
        tick();
        check("bad_sel_valid_1", 32'(b_out_valid), 32'd0);
        b_in_valid = 3'b000;

`ifdef STREAM_MUX_PKT_LOCK_EN
        // Packet lock: ch1 sends 3 words while ch0 competes, then ch0 gets its turn.
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        a_mode     = 1'b1;
        a_in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        a_in_last  = 4'b0000;
        a_in_valid = 4'b0010;
        #1;
        check("pkt_ready_0", 32'(a_in_ready), 32'b0010);
        tick();
        check("pkt_ch_0",   32'(a_out_ch),   32'd1);
        check("pkt_last_0", 32'(a_out_last), 32'd0);
        a_in_valid = 4'b0011;
        #1;
        check("pkt_ready_1", 32'(a_in_ready), 32'b0010);
        tick();
        check("pkt_ch_1", 32'(a_out_ch), 32'd1);
        a_in_last = 4'b0010;
        #1;
        check("pkt_ready_2", 32'(a_in_ready), 32'b0010);
        tick();
        check("pkt_ch_2",   32'(a_out_ch),   32'd1);
        check("pkt_last_2", 32'(a_out_last), 32'd1);
        a_in_last = 4'b0000;
        #1;
        check("pkt_ready_3", 32'(a_in_ready), 32'b0001);
        tick();
        check("pkt_ch_3",   32'(a_out_ch),   32'd0);
        check("pkt_last_3", 32'(a_out_last), 32'd0);

        // Reset mid-packet on ch0: lock released.
        rst = 1'b1;
        tick();
        check("pkt_rst_valid", 32'(a_out_valid), 32'd0);
        check("pkt_rst_last",  32'(a_out_last),  32'd0);
        rst        = 1'b0;
        a_in_valid = 4'b0010;
        #1;
        check("pkt_rst_unlock", 32'(a_in_ready), 32'b0010);
        a_in_valid = 4'h0;
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
